// File: rtl/reg_dump_pkg.sv
// Shared register-image types plus the reg_dump state and beat types.
// Used by reg_dump; optional zero-skip is enabled by REG_DUMP_SKIP_ZERO_EN.
package RegStruct;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned XLEN     = 64;

  typedef logic [NUM_REGS-1:0][XLEN-1:0] RegPack;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } dump_state_e;

  typedef struct packed {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
    logic            last;
  } DumpBeat;

endpackage

// File: rtl/reg_dump_snapshot.sv
// Snapshot buffer for reg_dump with per-index read and last-beat lookahead.
// With REG_DUMP_SKIP_ZERO_EN a nonzero mask is captured and zero entries are flagged.
module reg_dump_snapshot
  import RegStruct::*;
#(
  parameter int unsigned LAST_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  RegPack          regs,
  input  logic [4:0]      idx,
  output logic [XLEN-1:0] data,
  output logic            nonzero,
  output logic            last
);

  logic [XLEN-1:0] snap [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '{default: '0};
    end else if (capture) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        snap[i] <= regs[i];
      end
    end
  end

  assign data = snap[idx];

`ifdef REG_DUMP_SKIP_ZERO_EN
  logic [NUM_REGS-1:0] mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (capture) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mask[i] <= |regs[i];
      end
    end
  end

  // Current beat is last when no nonzero entry remains above idx within range.
  always_comb begin
    last = 1'b1;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ((5'(i) > idx) && (i <= LAST_REG) && mask[i]) begin
        last = 1'b0;
      end
    end
  end

  assign nonzero = mask[idx];
`else
  assign nonzero = 1'b1;
  assign last    = (idx == 5'(LAST_REG));
`endif

endmodule

// File: rtl/reg_dump.sv
// Snapshots the architectural register image on trigger and streams it out
// as valid/ready beats; REG_DUMP_SKIP_ZERO_EN (in reg_dump_snapshot) skips zero entries.
module reg_dump
  import RegStruct::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  RegPack      cosim_regs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [5:0]  beat_count
);

  dump_state_e     state, state_next;
  logic [4:0]      idx, idx_next;
  logic [5:0]      count, count_next;
  logic            capture;
  logic [XLEN-1:0] snap_data;
  logic            snap_nonzero;
  logic            snap_last;
  DumpBeat         beat;

  reg_dump_snapshot #(
    .LAST_REG (LAST_REG)
  ) u_snapshot (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .regs    (cosim_regs),
    .idx     (idx),
    .data    (snap_data),
    .nonzero (snap_nonzero),
    .last    (snap_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    count_next = count;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          capture    = 1'b1;
          idx_next   = 5'(FIRST_REG);
          count_next = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        // A zero entry (skip mode only) burns one cycle without a beat.
        if (!snap_nonzero) begin
          if (idx == 5'(LAST_REG)) state_next = DONE;
          else                     idx_next   = idx + 5'd1;
        end else if (out_ready) begin
          count_next = count + 6'd1;
          if (snap_last) state_next = DONE;
          else           idx_next   = idx + 5'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    beat.idx  = idx;
    beat.data = (state == SEND) ? snap_data : '0;
    beat.last = (state == SEND) && snap_nonzero && snap_last;
  end

  assign out_valid  = (state == SEND) && snap_nonzero;
  assign out_idx    = beat.idx;
  assign out_data   = beat.data;
  assign out_last   = beat.last;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign beat_count = count;

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: directed table, stall/reset sequences and
// randomized dumps against a queue-based model (honours REG_DUMP_SKIP_ZERO_EN).
module tb_reg_dump;
  import RegStruct::*;

  localparam int FIRST = 0;
  localparam int LAST  = 31;
`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  RegPack      cosim_regs;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [5:0]  beat_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_dump #(
    .FIRST_REG (FIRST),
    .LAST_REG  (LAST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .cosim_regs (cosim_regs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // mode 0: ready always high; 1: random ready and trigger noise; 2: 3-cycle stall at idx 7
  task automatic do_dump(input int mode, input bit mutate, output int n_beats, output int last_idx);
    logic [63:0] snap [32];
    int          exp_q[$];
    int          stall_left;
    bit          seen_stall;
    bit          prev_hold;
    bit          finished;
    logic [4:0]  p_idx;
    logic [63:0] p_data;
    logic        p_last;
    for (int i = 0; i < 32; i++) snap[i] = cosim_regs[i];
    for (int i = FIRST; i <= LAST; i++) if (!SKIP || snap[i] != 64'd0) exp_q.push_back(i);
    n_beats = 0; last_idx = -1; stall_left = 0; seen_stall = 0;
    prev_hold = 0; finished = 0; p_idx = '0; p_data = '0; p_last = 1'b0;
    @(negedge clk); trigger = 1'b1; out_ready = 1'b0;
    @(negedge clk); trigger = 1'b0;
    if (mutate) cosim_regs[5] = 64'hFFFF;
    if (exp_q.size() > 0 && exp_q[0] == FIRST) chk("latency_valid", 64'(out_valid), 64'd1);
    chk("busy_in_dump", 64'(busy), 64'd1);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_idx", 64'(out_idx), 64'(p_idx));
        chk("hold_data", out_data, p_data);
        chk("hold_last", 64'(out_last), 64'(p_last));
      end
      if (done) begin
        finished = 1;
        trigger  = 1'b0;
        chk("beats_left_at_done", 64'(exp_q.size()), 64'd0);
        chk("valid_in_done", 64'(out_valid), 64'd0);
        chk("count_at_done", 64'(beat_count), 64'(n_beats));
      end else begin
        case (mode)
          1: begin
            out_ready = 1'($urandom_range(0, 1));
            trigger   = 1'($urandom_range(0, 1));
          end
          2: begin
            if (out_valid && out_idx == 5'd7 && !seen_stall) begin
              stall_left = 3;
              seen_stall = 1;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
          end
          default: out_ready = 1'b1;
        endcase
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat_valid", 64'(out_valid), 64'd0);
          end else begin
            chk("beat_idx", 64'(out_idx), 64'(exp_q[0]));
            chk("beat_data", out_data, snap[exp_q[0]]);
            chk("beat_last", 64'(out_last), 64'(exp_q.size() == 1));
            if (out_ready) begin
              last_idx = exp_q.pop_front();
              n_beats++;
            end
          end
        end
        prev_hold = out_valid && !out_ready;
        p_idx = out_idx; p_data = out_data; p_last = out_last;
        @(negedge clk);
      end
    end
    if (!finished) chk("dump_timeout", 64'(finished), 64'd1);
    if (mode == 2) chk("stall_seen", 64'(seen_stall), 64'd1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_not_busy", 64'(busy), 64'd0);
    chk("count_hold", 64'(beat_count), 64'(n_beats));
  endtask

  typedef struct {
    int          ra;
    logic [63:0] va;
    int          rb;
    logic [63:0] vb;
    bit          mutate;
    int          cnt;
    int          last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n, li, nz;
    logic [63:0] v;

    vecs[0] = '{5,  64'h1234, 0, 64'h0, 1'b1, SKIP ? 1 : 32, SKIP ? 5  : 31};
    vecs[1] = '{3,  64'h1,    9, 64'h2, 1'b0, SKIP ? 2 : 32, SKIP ? 9  : 31};
    vecs[2] = '{0,  64'h0,    0, 64'h0, 1'b0, SKIP ? 0 : 32, SKIP ? -1 : 31};
    vecs[3] = '{31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h7, 1'b0, SKIP ? 2 : 32, 31};
    vecs[4] = '{30, 64'h8000_0000_0000_0000, 2, 64'hA5, 1'b0, SKIP ? 2 : 32, SKIP ? 30 : 31};

    rst = 1'b1; trigger = 1'b0; out_ready = 1'b0; cosim_regs = '0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_count", 64'(beat_count), 64'd0);
    trigger = 1'b1;
    @(negedge clk); rst = 1'b0; trigger = 1'b0;
    @(negedge clk);
    chk("trigger_in_rst_ignored", 64'(busy), 64'd0);

    // Directed table
    for (int t = 0; t < 5; t++) begin
      cosim_regs = '0;
      cosim_regs[vecs[t].ra] = vecs[t].va;
      if (vecs[t].rb != 0) cosim_regs[vecs[t].rb] = vecs[t].vb;
      do_dump(0, vecs[t].mutate, n, li);
      chk("tab_count", 64'(n), 64'(vecs[t].cnt));
      chk("tab_last_idx", 64'(li), 64'(vecs[t].last));
    end

    // Ready high while idle has no effect; beat_count holds
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready_busy", 64'(busy), 64'd0);
    chk("idle_ready_count", 64'(beat_count), 64'(vecs[4].cnt));
    out_ready = 1'b0;

    // Backpressure stall at idx 7
    for (int i = 0; i < 32; i++) cosim_regs[i] = {32'(i + 1), $urandom};
    do_dump(2, 1'b0, n, li);
    chk("stall_count", 64'(n), 64'd32);

    // Reset mid-dump at beat 10
    @(negedge clk); trigger = 1'b1; out_ready = 1'b1;
    @(negedge clk); trigger = 1'b0;
    for (int c = 0; c < 40 && !(out_idx == 5'd10 && busy); c++) @(negedge clk);
    chk("reached_idx10", 64'(out_idx), 64'd10);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_count", 64'(beat_count), 64'd0);
    chk("midrst_data", out_data, 64'd0);
    trigger = 1'b1;
    @(negedge clk); rst = 1'b0; trigger = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    do_dump(0, 1'b0, n, li);
    chk("restart_count", 64'(n), 64'd32);

    // Randomized dumps with sparse zero entries
    for (int r = 0; r < 20; r++) begin
      nz = 0;
      for (int i = 0; i < 32; i++) begin
        v = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom | 32'd1};
        cosim_regs[i] = v;
        if (!SKIP || v != 64'd0) nz++;
      end
      do_dump(1, 1'b0, n, li);
      chk("rand_count", 64'(n), 64'(nz));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
